// File: rtl/reduction_tree_pipe.sv
// rtl/reduction_tree_pipe.sv - pipelined, handshaked masked adder tree, one register per level
module reduction_tree_pipe #(
    parameter int NBIT        = 8,
    parameter int NUM_ADDENDS = 8,
    parameter int SIGNED      = 0,
    localparam int OW         = NBIT + $clog2(NUM_ADDENDS),
    localparam int LEVELS     = (NUM_ADDENDS > 1) ? $clog2(NUM_ADDENDS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_ADDENDS-1:0][NBIT-1:0]     data_in,
    input  logic [NUM_ADDENDS-1:0]               lane_mask,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [OW-1:0]                        result
);

    // Every level array carries one extra slot that is always zero, so an odd
    // last element pairs with zero and passes through unchanged.
    localparam int NP   = NUM_ADDENDS + 1;
    localparam int HALF = (NUM_ADDENDS + 1) / 2;

    logic [OW-1:0]     ext [NP];
    logic [OW-1:0]     nxt [LEVELS][NP];
    logic [OW-1:0]     stg [LEVELS][NP];
    logic [LEVELS-1:0] vld;
    logic              adv;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[LEVELS-1];
    assign result    = stg[LEVELS-1][0];

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            ext[i] = '0;
        end
        for (int i = 0; i < NUM_ADDENDS; i++) begin
            if (lane_mask[i]) begin
                if (SIGNED != 0) begin
                    ext[i] = OW'($signed(data_in[i]));
                end else begin
                    ext[i] = OW'(data_in[i]);
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LEVELS; l++) begin
            for (int j = 0; j < NP; j++) begin
                nxt[l][j] = '0;
            end
        end
        for (int j = 0; j < HALF; j++) begin
            nxt[0][j] = ext[2*j] + ext[2*j+1];
        end
        for (int l = 1; l < LEVELS; l++) begin
            for (int j = 0; j < HALF; j++) begin
                nxt[l][j] = stg[l-1][2*j] + stg[l-1][2*j+1];
            end
        end
    end

    // Global stall: the whole pipe, bubbles included, moves only when the output can drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int l = 0; l < LEVELS; l++) begin
                for (int j = 0; j < NP; j++) begin
                    stg[l][j] <= '0;
                end
            end
        end else if (adv) begin
            vld[0] <= in_valid;
            for (int l = 1; l < LEVELS; l++) begin
                vld[l] <= vld[l-1];
            end
            for (int l = 0; l < LEVELS; l++) begin
                for (int j = 0; j < NP; j++) begin
                    stg[l][j] <= nxt[l][j];
                end
            end
        end
    end

endmodule
